imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader that writes instruction words into the memory2c instance ahead of instruction fetch. The fetch path only ever reads that memory; this block is its writer.
- Accepts a byte stream over a valid/ready handshake and packs each group of 4 bytes, little-endian, into one 32-bit word.
- Writes each word to consecutive word addresses from BASE_ADDR.
- Holds the CPU in reset until the last word is written.

Parameters:
- LOAD_WORDS, 16, number of 32-bit words to load; legal range 1..65535.
- BASE_ADDR, 32'h0000_0000, byte address of the first word; must be 4-byte aligned.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a load; sampled only in IDLE.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_addr  out  32  memory address; connects to memory2c addr.
- mem_data_in  out  32  write data; connects to memory2c data_in.
- mem_enable  out  1  memory enable; connects to memory2c enable.
- mem_wr  out  1  write strobe; connects to memory2c wr.
- cpu_reset  out  1  reset to the CPU; high until the load completes.
- done  out  1  load complete.
- checksum  out  32  running sum of all written words, mod 2^32.

Behaviour:
- Reset values (first edge with reset=1):
  - state=IDLE; byte_cnt=0; word_idx=0; asm_word=0; checksum=0.
  - in_ready=0, mem_enable=0, mem_wr=0, done=0.
  - cpu_reset=1. cpu_reset is also forced to 1 combinationally while reset is high.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> COLLECT.
- COLLECT:
  - in_ready=1.
  - A byte is accepted only on a cycle with in_valid && in_ready. Accepted byte goes to asm_word[8*byte_cnt +: 8], then byte_cnt increments.
  - On the accept with byte_cnt==3 -> WRITE, byte_cnt returns to 0.
  - in_valid gaps are allowed. Nothing is consumed without in_valid.
- WRITE (exactly 1 cycle):
  - in_ready=0; mem_enable=1; mem_wr=1.
  - mem_data_in=asm_word.
  - checksum += asm_word at this edge.
  - If word_idx==LOAD_WORDS-1 -> DONE. Otherwise word_idx++ and -> COLLECT.
- DONE:
  - done=1, cpu_reset=0; in_ready=0.
  - start and in_valid are ignored. The block stays in DONE until reset.
- Addressing:
  - mem_addr = BASE_ADDR + 4*word_idx at all times, 32-bit arithmetic that wraps mod 2^32 with no error.
  - word_idx is 16 bits wide.
- Strobes: mem_enable and mem_wr are 0 in every state except WRITE.
- Throughput: at most one word per 5 cycles (4 accepts + 1 write). A stream held valid during WRITE is stalled, not dropped.
- Output timing:
  - done, cpu_reset and in_ready decode from the state register only. No combinational path exists from in_valid to in_ready.
  - The memory write and the DONE entry share the same edge, so the first CPU fetch happens at least 1 cycle after the final write.
- start while in COLLECT or WRITE is ignored.
- Reset mid-load:
  - Returns to IDLE and discards any partial word.
  - Words already written stay in memory. A new start reloads from word 0 at BASE_ADDR.
  - checksum clears.

Decomposition:
- Shared package/header holds:
  - state encoding localparams IDLE=2'd0, COLLECT=2'd1, WRITE=2'd2, DONE=2'd3;
  - BYTES_PER_WORD=4;
  - WORD_W=32.
- One natural sub-module, byte_packer: byte_cnt plus the asm_word shift/insert register. Inputs: clk, reset, accept, in_data. Outputs: word, word_full.
- FSM, address generation and checksum stay in imem_loader.

Test Plan:
- Basic load: LOAD_WORDS=2, BASE_ADDR=0, start, then bytes 78 56 34 12 EF BE AD DE back-to-back -> write 0x12345678@0x0 then 0xDEADBEEF@0x4; checksum=0xF0E21567; done=1 and cpu_reset=0 from the cycle after the second write.
- Bubbles: same bytes with in_valid low for 1-3 random cycles between bytes -> identical writes, exactly 2 mem_wr pulses, no duplicated or skipped bytes.
- Backpressure: in_valid held high with the next byte 0xAA during the WRITE cycle -> in_ready=0 that cycle; 0xAA is accepted the following cycle as byte 0 of the next word.
- Mid-load reset: reset after 6 of 8 bytes -> IDLE, cpu_reset=1, checksum=0; restart with 8 new bytes -> writes at 0x0 and 0x4 with the new data.
- Ignored inputs: bytes presented before start, and start plus bytes after DONE -> in_ready=0, no mem_wr pulse, state unchanged.
- Address wrap: BASE_ADDR=32'hFFFF_FFFC, LOAD_WORDS=2 -> writes at 0xFFFFFFFC and 0x00000000.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state type and the word/byte geometry used by the packer and the top.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 32;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: inserts accepted bytes into a 32-bit word, lowest byte first.
// word_full flags the accept that completes a word; the packed word is visible the next cycle.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic [7:0]        in_data,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [1:0]        r_byte_cnt;
  logic [WORD_W-1:0] r_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
        if (r_byte_cnt == i[1:0])
          r_word[8*i +: 8] <= in_data;
      end
      // Two-bit counter wraps 3 -> 0 on the word-completing accept.
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  assign word      = r_word;
  assign word_full = accept && (r_byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Program loader: packs a byte stream into words and writes them to instruction memory,
// holding the CPU in reset until the final word has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       LOAD_WORDS = 16,
  parameter logic [WORD_W-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data_in,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic              cpu_reset,
  output logic              done,
  output logic [WORD_W-1:0] checksum
);

  localparam logic [15:0] LAST_IDX = 16'(LOAD_WORDS - 1);

  state_t            r_state;
  logic [15:0]       r_word_idx;
  logic [WORD_W-1:0] r_checksum;
  logic [WORD_W-1:0] w_word;
  logic              w_word_full;
  logic              w_accept;

  assign w_accept = in_valid && in_ready;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .accept    (w_accept),
    .in_data   (in_data),
    .word      (w_word),
    .word_full (w_word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_word_idx <= '0;
      r_checksum <= '0;
    end else begin
      case (r_state)
        IDLE:    if (start) r_state <= COLLECT;
        COLLECT: if (w_word_full) r_state <= WRITE;
        WRITE: begin
          r_checksum <= r_checksum + w_word;
          if (r_word_idx == LAST_IDX) begin
            r_state <= DONE;
          end else begin
            r_word_idx <= r_word_idx + 16'd1;
            r_state    <= COLLECT;
          end
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake, strobes and status decode from the state register only.
  assign in_ready    = (r_state == COLLECT);
  assign mem_enable  = (r_state == WRITE);
  assign mem_wr      = (r_state == WRITE);
  assign done        = (r_state == DONE);
  assign cpu_reset   = reset || (r_state != DONE);
  assign mem_data_in = w_word;
  assign mem_addr    = BASE_ADDR + {14'd0, r_word_idx, 2'b00};
  assign checksum    = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven
// and popped by per-instance monitors whenever mem_wr is seen.
module tb_imem_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, v_a;
  logic [7:0]  d_a;
  logic        a_ready, a_en, a_wr, a_cpu, a_done;
  logic [31:0] a_addr, a_wdata, a_sum;

  logic        rst_b, start_b, v_b;
  logic [7:0]  d_b;
  logic        b_ready, b_en, b_wr, b_cpu, b_done;
  logic [31:0] b_addr, b_wdata, b_sum;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned wr_cnt_a = 0;
  int unsigned wr_cnt_b = 0;
  wr_t q_a[$];
  wr_t q_b[$];

  imem_loader #(.LOAD_WORDS(2), .BASE_ADDR(32'h0000_0000)) u_dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .in_valid(v_a), .in_data(d_a),
    .in_ready(a_ready), .mem_addr(a_addr), .mem_data_in(a_wdata), .mem_enable(a_en),
    .mem_wr(a_wr), .cpu_reset(a_cpu), .done(a_done), .checksum(a_sum)
  );

  imem_loader #(.LOAD_WORDS(2), .BASE_ADDR(32'hFFFF_FFFC)) u_dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .in_valid(v_b), .in_data(d_b),
    .in_ready(b_ready), .mem_addr(b_addr), .mem_data_in(b_wdata), .mem_enable(b_en),
    .mem_wr(b_wr), .cpu_reset(b_cpu), .done(b_done), .checksum(b_sum)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_wr) begin
      wr_cnt_a++;
      check("a_wr_enable", 32'(a_en), 32'd1);
      if (q_a.size() == 0) begin
        check("a_unexpected_wr", 32'(a_wr), 32'd0);
      end else begin
        wr_t e;
        e = q_a.pop_front();
        check("a_wr_addr", a_addr, e.addr);
        check("a_wr_data", a_wdata, e.data);
      end
    end
    if (b_wr) begin
      wr_cnt_b++;
      if (q_b.size() == 0) begin
        check("b_unexpected_wr", 32'(b_wr), 32'd0);
      end else begin
        wr_t e;
        e = q_b.pop_front();
        check("b_wr_addr", b_addr, e.addr);
        check("b_wr_data", b_wdata, e.data);
      end
    end
  end

  task automatic push_a(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    q_a.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input bit which, input logic [7:0] b);
    int unsigned cnt = 0;
    if (which) begin v_b = 1'b1; d_b = b; end
    else       begin v_a = 1'b1; d_a = b; end
    while (((which ? b_ready : a_ready) !== 1'b1) && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) check("byte_accept_timeout", 32'(cnt), 32'd0);
    @(negedge clk);
    if (which) v_b = 1'b0;
    else       v_a = 1'b0;
  endtask

  task automatic send_word(input bit which, input logic [31:0] w, input bit gaps);
    logic [31:0] tmp;
    tmp = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(which, tmp[8*i +: 8]);
      if (gaps) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic start_pulse(input bit which);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned w0;
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    v_a = 1'b0; v_b = 1'b0; d_a = '0; d_b = '0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    check("rst_in_ready", 32'(a_ready), 32'd0);
    check("rst_mem_en", 32'(a_en), 32'd0);
    check("rst_mem_wr", 32'(a_wr), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_cpu_reset", 32'(a_cpu), 32'd1);
    check("rst_checksum", a_sum, 32'd0);
    check("rst_addr_a", a_addr, 32'h0000_0000);
    check("rst_addr_b", b_addr, 32'hFFFF_FFFC);

    // Bytes before start are not consumed.
    v_a = 1'b1; d_a = 8'h99;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", 32'(a_ready), 32'd0);
    end
    v_a = 1'b0;

    // Basic back-to-back load.
    start_pulse(1'b0);
    check("collect_in_ready", 32'(a_ready), 32'd1);
    push_a(32'h0, 32'h1234_5678);
    push_a(32'h4, 32'hDEAD_BEEF);
    send_word(1'b0, 32'h1234_5678, 1'b0);
    send_word(1'b0, 32'hDEAD_BEEF, 1'b0);
    check("final_write_done", 32'(a_done), 32'd0);
    check("final_write_cpu_reset", 32'(a_cpu), 32'd1);
    @(negedge clk);
    check("basic_done", 32'(a_done), 32'd1);
    check("basic_cpu_reset", 32'(a_cpu), 32'd0);
    check("basic_checksum", a_sum, 32'hF0E2_1567);

    // Start and bytes after DONE are ignored.
    start_a = 1'b1; v_a = 1'b1; d_a = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check("done_in_ready", 32'(a_ready), 32'd0);
      check("done_hold", 32'(a_done), 32'd1);
    end
    start_a = 1'b0; v_a = 1'b0;

    // cpu_reset follows reset combinationally even from DONE.
    rst_a = 1'b1;
    #1;
    check("comb_cpu_reset", 32'(a_cpu), 32'd1);
    @(negedge clk);
    rst_a = 1'b0;

    // Reset after 6 of 8 bytes, then reload.
    start_pulse(1'b0);
    push_a(32'h0, 32'h4433_2211);
    send_word(1'b0, 32'h4433_2211, 1'b0);
    send_byte(1'b0, 8'h55);
    send_byte(1'b0, 8'h66);
    reset_a();
    check("midrst_checksum", a_sum, 32'd0);
    check("midrst_in_ready", 32'(a_ready), 32'd0);
    check("midrst_cpu_reset", 32'(a_cpu), 32'd1);
    check("midrst_addr", a_addr, 32'h0);
    start_pulse(1'b0);
    push_a(32'h0, 32'h0403_0201);
    push_a(32'h4, 32'h0807_0605);
    send_word(1'b0, 32'h0403_0201, 1'b0);
    send_word(1'b0, 32'h0807_0605, 1'b0);
    @(negedge clk);
    check("reload_done", 32'(a_done), 32'd1);
    check("reload_checksum", a_sum, 32'h0C0A_0806);

    // Random bubbles between bytes.
    reset_a();
    start_pulse(1'b0);
    w0 = wr_cnt_a;
    push_a(32'h0, 32'h1234_5678);
    push_a(32'h4, 32'hDEAD_BEEF);
    send_word(1'b0, 32'h1234_5678, 1'b1);
    send_word(1'b0, 32'hDEAD_BEEF, 1'b1);
    check("bubble_wr_pulses", wr_cnt_a - w0, 32'd2);
    check("bubble_checksum", a_sum, 32'hF0E2_1567);
    check("bubble_done", 32'(a_done), 32'd1);

    // Byte held valid through the WRITE cycle is stalled, then taken as byte 0.
    reset_a();
    start_pulse(1'b0);
    push_a(32'h0, 32'h1234_5678);
    push_a(32'h4, 32'hDDCC_BBAA);
    send_word(1'b0, 32'h1234_5678, 1'b0);
    v_a = 1'b1; d_a = 8'hAA;
    check("bp_in_ready_write", 32'(a_ready), 32'd0);
    send_word(1'b0, 32'hDDCC_BBAA, 1'b0);
    @(negedge clk);
    check("bp_checksum", a_sum, 32'hF001_1222);
    check("bp_done", 32'(a_done), 32'd1);

    // Address wrap at the top of the 32-bit space.
    begin
      wr_t e;
      e.addr = 32'hFFFF_FFFC; e.data = 32'h1234_5678; q_b.push_back(e);
      e.addr = 32'h0000_0000; e.data = 32'hDEAD_BEEF; q_b.push_back(e);
    end
    start_pulse(1'b1);
    send_word(1'b1, 32'h1234_5678, 1'b0);
    send_word(1'b1, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check("wrap_done", 32'(b_done), 32'd1);
    check("wrap_checksum", b_sum, 32'hF0E2_1567);
    check("wrap_wr_pulses", wr_cnt_b, 32'd2);

    repeat (2) @(negedge clk);
    check("queue_a_drained", q_a.size(), 32'd0);
    check("queue_b_drained", q_b.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
